// File: rtl/dmem_pkg.sv
// Shared size encodings, FSM states and fault helper for the MEM-stage data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Size 2'b11 has no legal access, so it is reported as a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offset[0];
            SZ_WORD: mis = (offset != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store enables/data and load extraction with extension.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        byte_en     = 4'b0000;
        wdata_lanes = 32'h0;
        case (size)
            SZ_BYTE: begin
                byte_en     = 4'b0001 << offset;
                wdata_lanes = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                byte_en     = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                byte_en     = 4'b1111;
                wdata_lanes = wdata;
            end
            default: ;
        endcase
    end

    // The addressed byte or half is shifted down to bit 0 before extension.
    always_comb begin
        shifted   = raw_word >> {offset, 3'b000};
        load_data = 32'h0;
        case (size)
            SZ_BYTE: load_data = unsigned_ld ? {24'h0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = unsigned_ld ? {16'h0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
            SZ_WORD: load_data = shifted;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory with req/ready handshake, wait states and fault detection.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        misalign_fault,
    output logic        range_fault
);

    localparam int          AW          = $clog2(DEPTH_BYTES);
    localparam logic [3:0]  WAIT_INIT   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_LIMIT = 32'(DEPTH_BYTES);

    state_t        state, next_state;
    logic [3:0]    wait_cnt;
    logic          armed, accept, commit;
    logic          req_mis, req_rng;
    logic          lat_we, lat_unsigned, lat_mis, lat_rng;
    logic [1:0]    lat_size;
    logic [AW-1:0] lat_addr, base;
    logic [31:0]   lat_wdata, raw_word, load_data, wdata_lanes;
    logic [3:0]    byte_en;
    logic [7:0]    mem [DEPTH_BYTES];

    // Full 32-bit compare so high address bits can never alias into the array.
    assign req_mis  = is_misaligned(size, addr[1:0]);
    assign req_rng  = !req_mis && (addr >= DEPTH_LIMIT);
    assign base     = lat_addr & ~AW'(3);
    assign raw_word = {mem[base | AW'(3)], mem[base | AW'(2)], mem[base | AW'(1)], mem[base]};

    dmem_lane_align u_lane_align (
        .size       (lat_size),
        .offset     (lat_addr[1:0]),
        .unsigned_ld(lat_unsigned),
        .wdata      (lat_wdata),
        .raw_word   (raw_word),
        .byte_en    (byte_en),
        .wdata_lanes(wdata_lanes),
        .load_data  (load_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Faults skip the wait states so their latency is always one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (req_mis || req_rng || WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        accept = (state == IDLE) && req && armed;
        commit = (state == RESP) && lat_we && !lat_mis && !lat_rng;
    end

    // armed holds off acceptance on the first edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed        <= 1'b0;
            wait_cnt     <= 4'd0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_mis      <= 1'b0;
            lat_rng      <= 1'b0;
            lat_size     <= SZ_BYTE;
            lat_addr     <= '0;
            lat_wdata    <= 32'h0;
        end else begin
            armed <= 1'b1;
            if (accept) begin
                wait_cnt     <= WAIT_INIT;
                lat_we       <= we;
                lat_unsigned <= unsigned_ld;
                lat_mis      <= req_mis;
                lat_rng      <= req_rng;
                lat_size     <= size;
                lat_addr     <= addr[AW-1:0];
                lat_wdata    <= wdata;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata          <= 32'h0;
            ready          <= 1'b0;
            misalign_fault <= 1'b0;
            range_fault    <= 1'b0;
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
        end else begin
            ready          <= (state == RESP);
            misalign_fault <= (state == RESP) && lat_mis;
            range_fault    <= (state == RESP) && lat_rng;
            rdata          <= (state == RESP && !lat_we && !lat_mis && !lat_rng) ? load_data : 32'h0;
            if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    if (byte_en[i]) mem[base | AW'(i)] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised byte-addressable data memory for the MEM stage of the pipelined MIPS32 core. It supports byte, halfword and word loads and stores with sign or zero extension, and a configurable number of wait states behind a req/ready handshake. It detects misaligned and out-of-range accesses. Contents are cleared on reset; there is no file I/O in the datapath.

## Interface
Parameters:
- DEPTH_BYTES, 1024: memory size in bytes; must be a multiple of 4 and at least 4.
- WAIT_CYCLES, 1: extra latency in cycles, legal range 0..15.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req  in  1  access request; sampled only when the block is idle.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- unsigned_ld  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend (LB/LH).
- wdata  in  32  store data, right-justified.
- rdata  out  32  load result; valid while ready = 1.
- ready  out  1  one-cycle completion pulse.
- busy  out  1  high while state is not IDLE.
- misalign_fault  out  1  valid with ready.
- range_fault  out  1  valid with ready.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE, req = 1: latch addr, we, size, unsigned_ld and wdata.
    - Faulting access: go to RESP.
    - WAIT_CYCLES = 0: go to RESP.
    - Otherwise: go to WAIT with wait counter = WAIT_CYCLES - 1.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: ready = 1 for one cycle, then return to IDLE unconditionally.
- req is ignored in WAIT and RESP. Maximum throughput is one access every WAIT_CYCLES + 2 cycles.
- Little-endian layout: byte at addr goes to bits [7:0].
- Store lanes: byte writes mem[a]. Half writes mem[a] and mem[a+1]. Word writes mem[a] through mem[a+3].
- Load assembly:
  - Byte and half results are sign- or zero-extended according to unsigned_ld.
  - Word results ignore unsigned_ld.
- Misaligned access, which raises misalign_fault:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11.
- Out-of-range access, which raises range_fault: addr >= DEPTH_BYTES. Upper address bits are never truncated or wrapped.
- Fault priority: misalign wins. Only one fault flag is asserted at a time.
- On any fault:
  - no memory write occurs;
  - rdata = 0;
  - ready still pulses;
  - latency is fixed at one cycle, independent of WAIT_CYCLES.

## Timing
- The request is accepted at rising edge k.
- Non-faulting access: ready, rdata and the flags are registered and asserted during the cycle after edge k + WAIT_CYCLES + 1.
- A store commits to the array at that same edge. A load issued after completion sees the new data.
- rdata, ready and the fault flags are all registered outputs.
- Outside a ready pulse: rdata and both flags are 0.
- Reset values: state IDLE, every memory byte 0x00, and rdata, ready, busy, misalign_fault and range_fault all 0.
- Reset asserted mid-operation (WAIT or RESP):
  - aborts the access;
  - a pending store is not committed;
  - no ready pulse follows the release of reset.
- req asserted in the same cycle reset deasserts is ignored.
- The first acceptable request is one edge after reset release.

## Structure
- Package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the FSM state enum;
  - the function computing the misalign condition.
- Sub-module dmem_lane_align, purely combinational:
  - store side: size plus addr[1:0] produce per-byte write enables and lane-steered write data;
  - load side: the raw 32-bit word plus size/offset/unsigned_ld produce the extended result.
- The top level holds the FSM, wait counter, request latches and byte array.

## Test plan
- Word round trip (WAIT_CYCLES = 1): SW 0xDEADBEEF at addr 8, then LW addr 8. ready rises 2 cycles after each acceptance; rdata = 0xDEADBEEF; busy is high during WAIT and RESP.
- Loads from the same word:
  - LB addr 9 → 0xFFFFFFBE;
  - LBU addr 9 → 0x000000BE;
  - LH addr 10 → 0xFFFFDEAD;
  - LHU addr 10 → 0x0000DEAD.
- Partial store: SH 0xAB1234 at addr 10, then LW 8 → 0x1234BEEF. Upper wdata bits are ignored.
- Faults:
  - LW addr 6 → misalign_fault = 1, rdata = 0, latency 1 cycle;
  - SW addr DEPTH_BYTES → range_fault = 1, memory unchanged;
  - size = 11 → misalign_fault.
- Reset: assert reset during WAIT of SW 0x11223344 at addr 0. No ready pulse; a subsequent LW 0 returns 0. Also check that req held high during the WAIT state is ignored.
- Parameter sweep WAIT_CYCLES ∈ {0, 3, 15}: ready appears exactly WAIT_CYCLES + 1 cycles after acceptance, for back-to-back requests held on req.
